// File: rtl/bcd_count_ctrl_pkg.sv
// Shared definitions for the 3-digit packed-BCD count controller:
// digit/width constants, the run/stop state type and a BCD validity helper.
package bcd_count_ctrl_pkg;

   localparam int BCD_DIGITS = 3;
   localparam int BCD_WIDTH  = 4 * BCD_DIGITS;

   localparam logic [BCD_WIDTH-1:0] BCD_MAX = 12'h999;

   typedef enum logic [1:0] {
      STATE_IDLE = 2'd0,
      STATE_RUN  = 2'd1,
      STATE_DONE = 2'd2
   } state_t;

   // True when any nibble holds a non-decimal code (A..F)
   function automatic logic isInvalidBcd(input logic [BCD_WIDTH-1:0] value);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (value[4*i +: 4] > 4'd9) begin
            bad = 1'b1;
         end
      end
      return bad;
   endfunction

endpackage

// File: rtl/bcd_count_ctrl_if.sv
// Control and status bundle between an event source and the BCD count
// controller; the master drives commands, the slave reports the count.
interface bcd_count_ctrl_if;
   import bcd_count_ctrl_pkg::*;

   logic                 start;
   logic                 stop;
   logic                 clear;
   logic                 load;
   logic [BCD_WIDTH-1:0] loadValue;
   logic [BCD_WIDTH-1:0] limit;
   logic                 mode;
   logic                 tick;

   logic [BCD_WIDTH-1:0] count;
   logic                 running;
   logic                 done;
   logic                 wrap;
   logic                 error;

   modport master (
      output start, stop, clear, load, loadValue, limit, mode, tick,
      input  count, running, done, wrap, error
   );

   modport slave (
      input  start, stop, clear, load, loadValue, limit, mode, tick,
      output count, running, done, wrap, error
   );

endinterface

// File: rtl/bcd3_step.sv
// Combinational packed-BCD "+1" across three digits; 999 rolls to 000 with
// carryOut high, which the controller also uses as its "count is 999" flag.
module bcd3_step
   import bcd_count_ctrl_pkg::*;
(
   input  logic [BCD_WIDTH-1:0] value,
   output logic [BCD_WIDTH-1:0] stepped,
   output logic                 carryOut
);

   logic       carry;
   logic [3:0] digit;

   // Ripple the +1 from the least significant digit upward
   always_comb begin
      carry   = 1'b1;
      digit   = 4'd0;
      stepped = '0;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         digit = value[4*i +: 4];
         if (carry && (digit >= 4'd9)) begin
            stepped[4*i +: 4] = 4'd0;
            carry             = 1'b1;
         end else if (carry) begin
            stepped[4*i +: 4] = digit + 4'd1;
            carry             = 1'b0;
         end else begin
            stepped[4*i +: 4] = digit;
         end
      end
      carryOut = carry;
   end

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/stop sequencer around a 3-digit BCD count register with a tick
// prescaler, programmable limit, wrap or halt behaviour and a sticky error.
module bcd_count_ctrl
   import bcd_count_ctrl_pkg::*;
#(
   parameter int TICK_DIV = 1
) (
   input  logic            clock,
   input  logic            reset,
   bcd_count_ctrl_if.slave bus
);

   localparam logic [7:0] PRESC_LAST = 8'(TICK_DIV - 1);

   state_t               state;
   state_t               stateNext;
   logic [BCD_WIDTH-1:0] count;
   logic [BCD_WIDTH-1:0] countNext;
   logic [BCD_WIDTH-1:0] countStep;
   logic                 countAtMax;
   logic [BCD_WIDTH-1:0] limitReg;
   logic [BCD_WIDTH-1:0] limitNext;
   logic [BCD_WIDTH-1:0] limitSampled;
   logic                 limitBad;
   logic                 loadBad;
   logic                 modeReg;
   logic                 modeNext;
   logic [7:0]           presc;
   logic [7:0]           prescNext;
   logic                 errorReg;
   logic                 errorNext;
   logic                 doneReg;
   logic                 doneNext;
   logic                 wrapReg;
   logic                 wrapNext;
   logic                 runningReg;

   bcd3_step stepInst (
      .value    (count),
      .stepped  (countStep),
      .carryOut (countAtMax)
   );

   assign limitBad     = isInvalidBcd(bus.limit);
   assign loadBad      = isInvalidBcd(bus.loadValue);
   assign limitSampled = limitBad ? BCD_MAX : bus.limit;

   // Only the highest-priority command acts; a Start seen while already
   // running is not a command, so a Tick in that cycle still counts.
   always_comb begin
      stateNext = state;
      countNext = count;
      limitNext = limitReg;
      modeNext  = modeReg;
      prescNext = presc;
      errorNext = errorReg;
      doneNext  = 1'b0;
      wrapNext  = 1'b0;

      if (bus.clear) begin
         countNext = '0;
         stateNext = STATE_IDLE;
         errorNext = 1'b0;
         prescNext = '0;
      end else if (bus.load) begin
         stateNext = STATE_IDLE;
         prescNext = '0;
         if (loadBad) begin
            errorNext = 1'b1;
         end else begin
            countNext = bus.loadValue;
         end
      end else if (bus.stop) begin
         if (state == STATE_RUN) begin
            stateNext = STATE_IDLE;
         end
      end else if (bus.start && (state != STATE_RUN)) begin
         prescNext = '0;
         modeNext  = bus.mode;
         limitNext = limitSampled;
         if (limitBad) begin
            errorNext = 1'b1;
         end
         if (state == STATE_DONE) begin
            countNext = '0;
            stateNext = STATE_RUN;
         end else if (bus.mode && (count == limitSampled)) begin
            stateNext = STATE_DONE;
            doneNext  = 1'b1;
         end else begin
            stateNext = STATE_RUN;
         end
      end else if ((state == STATE_RUN) && bus.tick) begin
         if (presc == PRESC_LAST) begin
            prescNext = '0;
            if (!modeReg) begin
               if ((count == limitReg) || countAtMax) begin
                  countNext = '0;
                  wrapNext  = 1'b1;
               end else begin
                  countNext = countStep;
               end
            end else if (countStep == limitReg) begin
               countNext = countStep;
               stateNext = STATE_DONE;
               doneNext  = 1'b1;
            end else if (countAtMax) begin
               countNext = '0;
               wrapNext  = 1'b1;
            end else begin
               countNext = countStep;
            end
         end else begin
            prescNext = presc + 8'd1;
         end
      end
   end

   // All state, including the registered status pulses, updates here
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= STATE_IDLE;
         count      <= '0;
         limitReg   <= BCD_MAX;
         modeReg    <= 1'b0;
         presc      <= '0;
         errorReg   <= 1'b0;
         doneReg    <= 1'b0;
         wrapReg    <= 1'b0;
         runningReg <= 1'b0;
      end else begin
         state      <= stateNext;
         count      <= countNext;
         limitReg   <= limitNext;
         modeReg    <= modeNext;
         presc      <= prescNext;
         errorReg   <= errorNext;
         doneReg    <= doneNext;
         wrapReg    <= wrapNext;
         runningReg <= (stateNext == STATE_RUN);
      end
   end

   assign bus.count   = count;
   assign bus.running = runningReg;
   assign bus.done    = doneReg;
   assign bus.wrap    = wrapReg;
   assign bus.error   = errorReg;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: two instances (TICK_DIV 1 and 3) share one
// stimulus stream and are compared every cycle against a decimal model.
module tb_bcd_count_ctrl;
   import bcd_count_ctrl_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int assertCount = 0;
   int failCount   = 0;

   bcd_count_ctrl_if busA ();
   bcd_count_ctrl_if busB ();

   bcd_count_ctrl #(.TICK_DIV(1)) dutA (
      .clock (clock),
      .reset (reset),
      .bus   (busA.slave)
   );

   bcd_count_ctrl #(.TICK_DIV(3)) dutB (
      .clock (clock),
      .reset (reset),
      .bus   (busB.slave)
   );

   always #5 clock = ~clock;

   // Model state in plain decimal; st: 0 idle, 1 run, 2 done
   int divOf [2] = '{1, 3};
   int mCount[2];
   int mLimit[2];
   int mTicks[2];
   int mSt   [2];
   bit mMode [2];
   bit mErr  [2];
   bit mDone [2];
   bit mWrap [2];

   function automatic logic [11:0] toBcd(input int d);
      return {4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
   endfunction

   function automatic int fromBcd(input logic [11:0] v);
      return int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic bit bcdOk(input logic [11:0] v);
      return (v[11:8] <= 4'd9) && (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
   endfunction

   task automatic modelStep(input int k, input bit rst, clr, ld, stp, sta,
                            tck, md, input logic [11:0] lv, lim);
      int nxt;
      mDone[k] = 1'b0;
      mWrap[k] = 1'b0;
      if (rst) begin
         mCount[k] = 0;   mLimit[k] = 999; mTicks[k] = 0;
         mSt[k]    = 0;   mMode[k]  = 1'b0; mErr[k] = 1'b0;
      end else if (clr) begin
         mCount[k] = 0; mSt[k] = 0; mErr[k] = 1'b0; mTicks[k] = 0;
      end else if (ld) begin
         mSt[k] = 0; mTicks[k] = 0;
         if (bcdOk(lv)) mCount[k] = fromBcd(lv);
         else mErr[k] = 1'b1;
      end else if (stp) begin
         if (mSt[k] == 1) mSt[k] = 0;
      end else if (sta && mSt[k] != 1) begin
         mTicks[k] = 0;
         mMode[k]  = md;
         if (bcdOk(lim)) mLimit[k] = fromBcd(lim);
         else begin
            mLimit[k] = 999;
            mErr[k]   = 1'b1;
         end
         if (mSt[k] == 2) begin
            mCount[k] = 0;
            mSt[k]    = 1;
         end else if (md && mCount[k] == mLimit[k]) begin
            mSt[k]   = 2;
            mDone[k] = 1'b1;
         end else mSt[k] = 1;
      end else if (mSt[k] == 1 && tck) begin
         mTicks[k]++;
         if (mTicks[k] == divOf[k]) begin
            mTicks[k] = 0;
            nxt = (mCount[k] + 1) % 1000;
            if (!mMode[k]) begin
               if (mCount[k] == mLimit[k] || mCount[k] == 999) begin
                  mCount[k] = 0;
                  mWrap[k]  = 1'b1;
               end else mCount[k] = nxt;
            end else if (nxt == mLimit[k]) begin
               mCount[k] = nxt;
               mSt[k]    = 2;
               mDone[k]  = 1'b1;
            end else if (mCount[k] == 999) begin
               mCount[k] = 0;
               mWrap[k]  = 1'b1;
            end else mCount[k] = nxt;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll();
      checkOutput("A.count",   32'(busA.count),   32'(toBcd(mCount[0])));
      checkOutput("A.running", 32'(busA.running), 32'(mSt[0] == 1));
      checkOutput("A.done",    32'(busA.done),    32'(mDone[0]));
      checkOutput("A.wrap",    32'(busA.wrap),    32'(mWrap[0]));
      checkOutput("A.error",   32'(busA.error),   32'(mErr[0]));
      checkOutput("B.count",   32'(busB.count),   32'(toBcd(mCount[1])));
      checkOutput("B.running", 32'(busB.running), 32'(mSt[1] == 1));
      checkOutput("B.done",    32'(busB.done),    32'(mDone[1]));
      checkOutput("B.wrap",    32'(busB.wrap),    32'(mWrap[1]));
      checkOutput("B.error",   32'(busB.error),   32'(mErr[1]));
   endtask

   // Drive one cycle of commands to both instances, step the model, compare
   task automatic applyStimulus(input bit rst, clr, ld, stp, sta, tck, md,
                                input logic [11:0] lv, lim);
      reset          = rst;
      busA.clear     = clr;  busB.clear     = clr;
      busA.load      = ld;   busB.load      = ld;
      busA.stop      = stp;  busB.stop      = stp;
      busA.start     = sta;  busB.start     = sta;
      busA.tick      = tck;  busB.tick      = tck;
      busA.mode      = md;   busB.mode      = md;
      busA.loadValue = lv;   busB.loadValue = lv;
      busA.limit     = lim;  busB.limit     = lim;
      for (int k = 0; k < 2; k++) modelStep(k, rst, clr, ld, stp, sta, tck, md, lv, lim);
      @(posedge clock);
      @(negedge clock);
      checkAll();
   endtask

   bit          rRst, rClr, rLd, rStp, rSta, rTck, rMd;
   logic [11:0] rLv, rLim;

   function automatic logic [11:0] randValue();
      case ($urandom_range(0, 3))
         0:       return 12'($urandom);
         1:       return toBcd(int'($urandom_range(990, 999)));
         default: return toBcd(int'($urandom_range(0, 40)));
      endcase
   endfunction

   initial begin
      $display("[TB] start");
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 12'h000, 12'h000);
      checkOutput("rstCount", 32'(busA.count), 32'h000);

      // Mode=1 up to limit 005; the Tick alongside Start is not counted
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 12'h000, 12'h005);
      checkOutput("t1startCount", 32'(busA.count), 32'h000);
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
         checkOutput("t1count", 32'(busA.count), 32'(i));
         checkOutput("t1done", 32'(busA.done), 32'(i == 5));
      end
      checkOutput("t1running", 32'(busA.running), 32'h0);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t1frozen", 32'(busA.count), 32'h005);

      // Digit carry and full rollover
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h099, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h999);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t2carry", 32'(busA.count), 32'h100);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h999, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h999);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t2roll", 32'(busA.count), 32'h000);
      checkOutput("t2wrap", 32'(busA.wrap), 32'h1);

      // Mode=0 wrap at limit 012
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h010, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h012);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t3atLimit", 32'(busA.count), 32'h012);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t3wrapCount", 32'(busA.count), 32'h000);
      checkOutput("t3wrap", 32'(busA.wrap), 32'h1);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t3after", 32'(busA.count), 32'h001);
      checkOutput("t3noDone", 32'(busA.done), 32'h0);

      // Prescaler of 3 on instance B; Stop then Start discards partial ticks
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h999);
      repeat (7) applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t4div", 32'(busB.count), 32'h002);
      applyStimulus(0, 0, 0, 1, 0, 0, 0, 12'h000, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h999);
      repeat (2) applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t4discard", 32'(busB.count), 32'h002);
      checkOutput("t4countA", 32'(busA.count), 32'h009);

      // Stop beats Tick
      applyStimulus(0, 0, 0, 1, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t6stopTick", 32'(busA.count), 32'h009);
      checkOutput("t6stopRun", 32'(busA.running), 32'h0);

      // Invalid BCD handling
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h0A3, 12'h000);
      checkOutput("t5badLoad", 32'(busA.count), 32'h009);
      checkOutput("t5errSet", 32'(busA.error), 32'h1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 12'h000, 12'h000);
      checkOutput("t5errClr", 32'(busA.error), 32'h0);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h1F0);
      checkOutput("t5badLimit", 32'(busA.error), 32'h1);

      // Clear beats Load; Reset in the middle of a run
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 12'h123, 12'h000);
      checkOutput("t6clrLoad", 32'(busA.count), 32'h000);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 12'h046, 12'h000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0, 12'h000, 12'h999);
      applyStimulus(0, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t6at047", 32'(busA.count), 32'h047);
      applyStimulus(1, 0, 0, 0, 0, 1, 0, 12'h000, 12'h000);
      checkOutput("t6rstCount", 32'(busA.count), 32'h000);
      checkOutput("t6rstRun", 32'(busA.running), 32'h0);

      // Randomized commands against the model
      for (int n = 0; n < 600; n++) begin
         rRst = ($urandom_range(0, 99) == 0);
         rClr = ($urandom_range(0, 39) == 0);
         rLd  = ($urandom_range(0, 19) == 0);
         rStp = ($urandom_range(0, 15) == 0);
         rSta = ($urandom_range(0, 7) == 0);
         rTck = ($urandom_range(0, 3) != 0);
         rMd  = 1'($urandom);
         rLv  = randValue();
         rLim = randValue();
         applyStimulus(rRst, rClr, rLd, rStp, rSta, rTck, rMd, rLv, rLim);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
